vs_spi_responder: RTL and testbench

//  Synthesizable responder for the VS10xx-style SCI/SDI serial link that our MP3 player drives.

---
 rtl/vs_spi_responder.sv | 194 +++++++++++++++++++
 tb/tb_vs_spi_responder.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vs_spi_responder.sv
// vs_spi_responder: VS10xx-style SCI/SDI responder with SCI register file, SDI byte FIFO and DREQ flow control.
module vs_spi_responder #(
    parameter int FIFO_DEPTH   = 64,
    parameter int DREQ_FREE    = 32,
    parameter int SCI_BUSY_CYC = 16
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       MP3_SCLK,
    input  logic       MP3_CS,
    input  logic       MP3_DCS,
    input  logic       MP3_MOSI,
    output logic       MP3_MISO,
    output logic       MP3_DREQ,
    output logic [15:0] SCI_MODE,
    output logic [15:0] SCI_VOL,
    output logic       SOFT_RST,
    output logic [7:0] FIFO_DATA,
    output logic       FIFO_VALID,
    input  logic       FIFO_READY,
    output logic       OVERFLOW,
    output logic       PROTO_ERR
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int BW = $clog2(SCI_BUSY_CYC + 1);
    localparam logic [2:0] S_IDLE = 3'd0, S_OPC = 3'd1, S_ADDR = 3'd2, S_DATA = 3'd3, S_DONE = 3'd4;

    logic [7:0]    sync_q, sync_d;
    logic          sclk_p_q, sclk_p_d;
    logic [2:0]    state_q, state_d;
    logic [4:0]    bcnt_q, bcnt_d;
    logic [31:0]   sr_q, sr_d, sr_n;
    logic [15:0]   tx_q, tx_d;
    logic          rd_q, rd_d, miso_q, miso_d;
    logic [15:0]   reg_q [16];
    logic [15:0]   reg_d [16];
    logic          soft_q, soft_d;
    logic [BW-1:0] busy_q, busy_d;
    logic [7:0]    sdi_sr_q, sdi_sr_d, pbyte_q, pbyte_d;
    logic [2:0]    sdi_cnt_q, sdi_cnt_d;
    logic [1:0]    pend_q, pend_d;
    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          ovf_q, ovf_d, perr_q, perr_d, dreq_q, dreq_d;
    logic          we, byte_done, pop, acc;
    logic          sclk_s, cs_s, dcs_s, mosi_s, rise, fall;
    logic [3:0]    waddr;
    logic [15:0]   wdata;

    assign {sclk_s, cs_s, dcs_s, mosi_s} = sync_q[7:4];
    assign rise  = sclk_s & ~sclk_p_q;
    assign fall  = ~sclk_s & sclk_p_q;
    assign sr_n  = {sr_q[30:0], mosi_s};
    assign waddr = sr_n[19:16];
    assign wdata = sr_n[15:0];
    assign pop   = (cnt_q != '0) && FIFO_READY;
    assign acc   = pend_q[1] && (cnt_q != CW'(FIFO_DEPTH) || pop);

    always_comb begin
        sync_d   = {sync_q[3:0], MP3_SCLK, MP3_CS, MP3_DCS, MP3_MOSI};
        sclk_p_d = sclk_s;
        state_d  = state_q;
        bcnt_d   = bcnt_q;
        sr_d     = sr_q;
        tx_d     = tx_q;
        rd_d     = rd_q;
        miso_d   = miso_q;
        we       = 1'b0;
        if (cs_s) begin
            state_d = S_IDLE;
            rd_d    = 1'b0;
            miso_d  = 1'b0;
        end else if (state_q == S_IDLE) begin
            state_d = S_OPC;
            bcnt_d  = '0;
        end else begin
            if (rise && state_q != S_DONE) begin
                sr_d   = sr_n;
                bcnt_d = bcnt_q + 5'd1;
                if (bcnt_q == 5'd7) state_d = S_ADDR;
                if (bcnt_q == 5'd15) begin
                    state_d = S_DATA;
                    rd_d    = sr_n[15:8] == 8'h03;
                    tx_d    = sr_n[7:4] == 4'h0 ? reg_q[sr_n[3:0]] : 16'h0000;
                end
                if (bcnt_q == 5'd31) begin
                    state_d = S_DONE;
                    we      = sr_n[31:24] == 8'h02 && sr_n[23:20] == 4'h0;
                end
            end
            if (fall && rd_q) begin
                miso_d = tx_q[15];
                tx_d   = {tx_q[14:0], 1'b0};
            end
        end
    end

    // SM_RESET is never stored; writing it only produces the pulse and the FIFO flush.
    always_comb begin
        reg_d  = reg_q;
        soft_d = 1'b0;
        busy_d = busy_q != '0 ? busy_q - BW'(1) : '0;
        if (we) begin
            reg_d[waddr] = waddr == 4'h0 ? (wdata & 16'hFFFB) : wdata;
            soft_d       = waddr == 4'h0 && wdata[2];
            busy_d       = BW'(SCI_BUSY_CYC);
        end
    end

    always_comb begin
        sdi_sr_d  = sdi_sr_q;
        sdi_cnt_d = sdi_cnt_q;
        byte_done = 1'b0;
        if (dcs_s) begin
            sdi_cnt_d = '0;
        end else if (cs_s && rise) begin
            sdi_sr_d  = {sdi_sr_q[6:0], mosi_s};
            sdi_cnt_d = sdi_cnt_q + 3'd1;
            byte_done = sdi_cnt_q == 3'd7;
        end
        pend_d  = {pend_q[0], byte_done};
        pbyte_d = byte_done ? {sdi_sr_q[6:0], mosi_s} : pbyte_q;
        perr_d  = perr_q | (~cs_s & ~dcs_s);
        ovf_d   = ovf_q | (pend_q[1] & ~acc);
        wptr_d  = soft_d ? '0 : wptr_q + AW'(acc);
        rptr_d  = soft_d ? '0 : rptr_q + AW'(pop);
        cnt_d   = soft_d ? '0 : cnt_q + CW'(acc) - CW'(pop);
        dreq_d  = cnt_d <= CW'(FIFO_DEPTH - DREQ_FREE) && busy_d == '0;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            sync_q    <= 8'b0110_0110;
            sclk_p_q  <= 1'b0;
            state_q   <= S_IDLE;
            bcnt_q    <= '0;
            sr_q      <= '0;
            tx_q      <= '0;
            rd_q      <= 1'b0;
            miso_q    <= 1'b0;
            for (int i = 0; i < 16; i++) reg_q[i] <= i == 0 ? 16'h0800 : 16'h0000;
            soft_q    <= 1'b0;
            busy_q    <= '0;
            sdi_sr_q  <= '0;
            sdi_cnt_q <= '0;
            pend_q    <= '0;
            pbyte_q   <= '0;
            wptr_q    <= '0;
            rptr_q    <= '0;
            cnt_q     <= '0;
            ovf_q     <= 1'b0;
            perr_q    <= 1'b0;
            dreq_q    <= 1'b0;
        end else begin
            sync_q    <= sync_d;
            sclk_p_q  <= sclk_p_d;
            state_q   <= state_d;
            bcnt_q    <= bcnt_d;
            sr_q      <= sr_d;
            tx_q      <= tx_d;
            rd_q      <= rd_d;
            miso_q    <= miso_d;
            reg_q     <= reg_d;
            soft_q    <= soft_d;
            busy_q    <= busy_d;
            sdi_sr_q  <= sdi_sr_d;
            sdi_cnt_q <= sdi_cnt_d;
            pend_q    <= pend_d;
            pbyte_q   <= pbyte_d;
            wptr_q    <= wptr_d;
            rptr_q    <= rptr_d;
            cnt_q     <= cnt_d;
            ovf_q     <= ovf_d;
            perr_q    <= perr_d;
            dreq_q    <= dreq_d;
        end
    end

    always_ff @(posedge CLK) begin
        if (acc) mem_q[wptr_q] <= pbyte_q;
    end

    assign MP3_MISO   = miso_q;
    assign MP3_DREQ   = dreq_q;
    assign SCI_MODE   = reg_q[0];
    assign SCI_VOL    = reg_q[11];
    assign SOFT_RST   = soft_q;
    assign FIFO_VALID = cnt_q != '0;
    assign FIFO_DATA  = cnt_q != '0 ? mem_q[rptr_q] : 8'h00;
    assign OVERFLOW   = ovf_q;
    assign PROTO_ERR  = perr_q;
endmodule

// File: tb/tb_vs_spi_responder.sv
// tb_vs_spi_responder: randomized SCI/SDI traffic checked every settled cycle against a register/queue model.
module tb_vs_spi_responder;
    logic CLK = 0, RST = 1, SCLK = 0, CS = 1, DCS = 1, MOSI = 0, READY = 0;
    logic MISO, DREQ, SOFT, VALID, OVF, PERR;
    logic [15:0] MODE, VOL;
    logic [7:0] DATA;

    vs_spi_responder dut (
        .CLK(CLK), .RST(RST), .MP3_SCLK(SCLK), .MP3_CS(CS), .MP3_DCS(DCS), .MP3_MOSI(MOSI),
        .MP3_MISO(MISO), .MP3_DREQ(DREQ), .SCI_MODE(MODE), .SCI_VOL(VOL), .SOFT_RST(SOFT),
        .FIFO_DATA(DATA), .FIFO_VALID(VALID), .FIFO_READY(READY), .OVERFLOW(OVF), .PROTO_ERR(PERR)
    );

    always #5 CLK = ~CLK;

    int nvec = 0, nerr = 0, soft_cnt = 0, dlow_cnt = 0;
    bit chk_en = 0, dlow_en = 0;
    logic [15:0] m_reg [16];
    logic [7:0] q[$];
    bit m_ovf, m_perr;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic m_reset();
        for (int i = 0; i < 16; i++) m_reg[i] = 16'h0000;
        m_reg[0] = 16'h0800;
        q.delete();
        m_ovf = 0;
        m_perr = 0;
    endtask

    function automatic logic [15:0] m_sci(input logic [7:0] opc, input logic [7:0] addr, input logic [15:0] data);
        if (opc == 8'h02 && addr < 16) begin
            m_reg[addr[3:0]] = addr == 0 ? {data[15:3], 1'b0, data[1:0]} : data;
            if (addr == 0 && data[2]) q.delete();
        end
        return (opc == 8'h03 && addr < 16) ? m_reg[addr[3:0]] : 16'h0000;
    endfunction

    task automatic m_push(input logic [7:0] b);
        if (q.size() < 64) q.push_back(b);
        else m_ovf = 1;
    endtask

    always @(negedge CLK) begin
        if (SOFT) soft_cnt++;
        if (dlow_en && !DREQ) dlow_cnt++;
        if (chk_en) begin
            chk("mode", MODE, m_reg[0]);
            chk("vol", VOL, m_reg[11]);
            chk("valid", VALID, q.size() != 0);
            if (q.size() != 0) chk("data", DATA, q[0]);
            chk("overflow", OVF, m_ovf);
            chk("proto_err", PERR, m_perr);
            chk("dreq", DREQ, (64 - q.size()) >= 32);
            chk("miso_idle", MISO, 0);
            chk("soft_rst_idle", SOFT, 0);
        end
    end

    always @(posedge CLK) if (chk_en && READY && q.size() != 0) void'(q.pop_front());

    task automatic ph();
        repeat (6) @(negedge CLK);
    endtask

    task automatic sci(input logic [7:0] opc, input logic [7:0] addr, input logic [15:0] data,
                       input int nbits, input bit dcs_too, output logic [15:0] rdata);
        logic [31:0] w;
        w = {opc, addr, data};
        rdata = 0;
        CS = 0;
        if (dcs_too) DCS = 0;
        ph();
        for (int i = 0; i < nbits; i++) begin
            SCLK = 0; MOSI = w[31-i]; ph();
            if (i >= 16) rdata = {rdata[14:0], MISO};
            SCLK = 1; ph();
        end
        SCLK = 0; ph();
        CS = 1; DCS = 1; ph();
    endtask

    task automatic sdi_bits(input logic [7:0] b, input int n);
        DCS = 0; ph();
        for (int i = 0; i < n; i++) begin
            SCLK = 0; MOSI = b[7-i]; ph();
            SCLK = 1; ph();
        end
        SCLK = 0; ph();
        DCS = 1; ph();
    endtask

    task automatic settle();
        repeat (20) @(negedge CLK);
        chk_en = 1;
        repeat (3) @(negedge CLK);
        chk_en = 0;
    endtask

    task automatic drain();
        int t;
        t = 0;
        chk_en = 1;
        READY = 1;
        while (q.size() != 0 && t < 300) begin
            @(negedge CLK);
            t++;
        end
        READY = 0;
        chk("drain_done", q.size(), 0);
        repeat (3) @(negedge CLK);
        chk_en = 0;
    endtask

    task automatic reset_checks();
        chk("rst_miso", MISO, 0);
        chk("rst_dreq", DREQ, 0);
        chk("rst_mode", MODE, 16'h0800);
        chk("rst_vol", VOL, 16'h0000);
        chk("rst_soft", SOFT, 0);
        chk("rst_valid", VALID, 0);
        chk("rst_data", DATA, 8'h00);
        chk("rst_ovf", OVF, 0);
        chk("rst_perr", PERR, 0);
    endtask

    initial begin
        logic [15:0] rd, exp_rd;
        logic [7:0] opc, addr, b;
        logic [15:0] d;
        m_reset();
        repeat (3) @(negedge CLK);
        reset_checks();
        RST = 0;
        @(posedge CLK); #1;
        chk("dreq_after_rst", DREQ, 1);
        settle();

        soft_cnt = 0; dlow_cnt = 0; dlow_en = 1;
        sci(8'h02, 8'h00, 16'h0804, 32, 0, rd);
        void'(m_sci(8'h02, 8'h00, 16'h0804));
        repeat (30) @(negedge CLK);
        dlow_en = 0;
        chk("mode_sm_reset_clear", MODE, 16'h0800);
        chk("soft_rst_pulses", soft_cnt, 1);
        chk("dreq_busy_mode", dlow_cnt, 16);
        dlow_cnt = 0; dlow_en = 1;
        sci(8'h02, 8'h0B, 16'h1010, 32, 0, rd);
        void'(m_sci(8'h02, 8'h0B, 16'h1010));
        repeat (30) @(negedge CLK);
        dlow_en = 0;
        chk("vol_1010", VOL, 16'h1010);
        chk("dreq_busy_vol", dlow_cnt, 16);
        chk("soft_rst_once", soft_cnt, 1);
        settle();

        sci(8'h02, 8'h0B, 16'h2A2A, 32, 0, rd);
        void'(m_sci(8'h02, 8'h0B, 16'h2A2A));
        sci(8'h03, 8'h0B, 16'h0000, 32, 0, rd);
        chk("read_vol", rd, 16'h2A2A);
        sci(8'h03, 8'h00, 16'h0000, 32, 0, rd);
        chk("read_mode", rd, 16'h0800);
        sci(8'h03, 8'h15, 16'h0000, 32, 0, rd);
        chk("read_high_addr", rd, 16'h0000);
        settle();

        for (int i = 0; i < 33; i++) begin
            sdi_bits(8'(i), 8);
            m_push(8'(i));
            if (i == 31) chk("dreq_32_bytes", DREQ, 1);
            if (i == 32) chk("dreq_33_bytes", DREQ, 0);
        end
        chk("burst_head", DATA, 8'h00);
        settle();
        drain();

        for (int i = 0; i < 65; i++) begin
            b = 8'($urandom);
            sdi_bits(b, 8);
            m_push(b);
        end
        chk("overflow_set", OVF, 1);
        settle();
        drain();

        sci(8'h02, 8'h0B, 16'h5555, 20, 0, rd);
        repeat (10) @(negedge CLK);
        chk("vol_after_abort", VOL, 16'h2A2A);
        sci(8'h02, 8'h0B, 16'h5555, 32, 0, rd);
        void'(m_sci(8'h02, 8'h0B, 16'h5555));
        repeat (10) @(negedge CLK);
        chk("vol_after_retry", VOL, 16'h5555);
        settle();

        sdi_bits(8'hFF, 4);
        sdi_bits(8'hC3, 8);
        m_push(8'hC3);
        chk("partial_dropped", DATA, 8'hC3);
        settle();
        drain();

        sdi_bits(8'h5A, 8); m_push(8'h5A);
        sdi_bits(8'hA5, 8); m_push(8'hA5);
        sci(8'h02, 8'h0B, 16'h1234, 32, 1, rd);
        void'(m_sci(8'h02, 8'h0B, 16'h1234));
        m_perr = 1;
        repeat (10) @(negedge CLK);
        chk("proto_err_set", PERR, 1);
        chk("vol_under_proto", VOL, 16'h1234);
        settle();
        drain();

        repeat (25) begin
            case ($urandom_range(0, 3))
                0: begin
                    addr = 8'($urandom_range(0, 19));
                    d = 16'($urandom);
                    sci(8'h02, addr, d, 32, 0, rd);
                    void'(m_sci(8'h02, addr, d));
                end
                1: begin
                    addr = 8'($urandom_range(0, 19));
                    sci(8'h03, addr, 16'($urandom), 32, 0, rd);
                    exp_rd = m_sci(8'h03, addr, 16'h0000);
                    chk("rand_read", rd, exp_rd);
                end
                2: begin
                    opc = 8'($urandom);
                    addr = 8'($urandom_range(0, 15));
                    d = 16'($urandom);
                    sci(opc, addr, d, 32, 0, rd);
                    exp_rd = m_sci(opc, addr, d);
                    if (opc == 8'h03) chk("rand_op_read", rd, exp_rd);
                end
                default: begin
                    repeat ($urandom_range(1, 6)) begin
                        b = 8'($urandom);
                        sdi_bits(b, 8);
                        m_push(b);
                    end
                end
            endcase
            settle();
            if ($urandom_range(0, 2) == 0) drain();
        end
        drain();

        for (int i = 0; i < 3; i++) begin
            sdi_bits(8'(8'h40 + i), 8);
            m_push(8'(8'h40 + i));
        end
        settle();
        DCS = 0; ph();
        for (int i = 0; i < 3; i++) begin
            SCLK = 0; MOSI = 1; ph();
            SCLK = 1; ph();
        end
        @(negedge CLK);
        RST = 1;
        #2;
        reset_checks();
        SCLK = 0; DCS = 1; MOSI = 0;
        repeat (3) @(negedge CLK);
        RST = 0;
        m_reset();
        @(posedge CLK); #1;
        chk("dreq_after_mid_rst", DREQ, 1);
        settle();

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
